jtcontra_snd_cmdq: RTL
======================

// Module: jtcontra_snd_cmdq
// PURPOSE
//  Multi-channel command queue between main CPU and sound CPU, successor to the single
//  sound latch + edge IRQ flip-flop. Each channel is a small FIFO; the IRQ is derived
//  from queue state. Sits inside the sound subsystem, fed by the main-CPU write decode.
// PARAMETERS
//  CH       2  number of command channels (1..4); CHW = CH>1 ? $clog2(CH) : 1
//  DW       8  command data width
//  AW       2  FIFO address width; depth per channel = 2**AW
//  IRQ_MODE 0  0: level IRQ while any channel non-empty; 1: sticky flag set on write, cleared by ack
// PORTS
//  clk          in   1        system clock (24 MHz)
//  rst          in   1        synchronous, active-high reset
//  main_wr      in   1        one-cycle write strobe from main CPU
//  main_ch      in   CHW      target channel for main_wr
//  main_din     in   DW       command byte
//  main_full    out  CH       per-channel full flag
//  snd_rd       in   1        one-cycle pop strobe; caller qualifies it with the CPU cen
//  snd_ch       in   CHW      channel selected for snd_dout / snd_rd
//  snd_dout     out  DW       head of selected channel (combinational from registers)
//  snd_empty    out  CH       per-channel empty flag
//  ovf          out  CH       sticky overflow flag per channel
//  irq_ack      in   1        one-cycle strobe: clears IRQ flag (mode 1) and all ovf bits
//  irq_n        out  1        active-low IRQ to sound CPU
//  snd_reply_wr in   1        reply write strobe (JTCONTRA_SNDQ_REPLY_EN only)
//  snd_reply_din in  DW       reply data
//  main_reply_rd in  1        main CPU reads reply
//  main_reply_dout out DW     reply data to main CPU
//  main_reply_rdy out 1       reply pending
// BEHAVIOUR
//  Reset: pointers/counts 0, snd_empty all 1, main_full all 0, ovf 0, irq_n 1,
//   hold registers 0 -> snd_dout 0, main_reply_dout 0, main_reply_rdy 0.
//  Write: main_wr with channel not full stores main_din at wr_ptr; count+1 next edge.
//   Write to full channel (no simultaneous pop): data dropped, ovf[ch] set.
//  Read: snd_dout = mem[rd_ptr] of snd_ch when non-empty, else that channel's hold reg
//   (last popped value). snd_rd on non-empty: hold<=head, rd_ptr+1, count-1.
//   snd_rd on empty: no state change.
//  Same channel, same cycle: pop+push on full -> both occur, count unchanged, no ovf.
//   Push+pop on empty -> push only; no bypass; snd_dout shows new data next cycle.
//  Pointers wrap modulo 2**AW; count is AW+1 bits, full when count==2**AW.
//  IRQ_MODE 0: irq_n = ~|(~snd_empty), registered (1-cycle lag after state update).
//  IRQ_MODE 1: flag set on any accepted write, cleared by irq_ack; set wins when both
//   happen in the same cycle; irq_n = ~flag.
//  irq_ack with ovf set and a simultaneous overflowing write: ovf stays set.
//  main_ch/snd_ch >= CH: write ignored (no ovf); snd_dout reads 0.
//  rst mid-operation discards all queued data; outputs return to reset values next edge.
// CONFIGURATION
//  JTCONTRA_SNDQ_REPLY_EN defined: one DW reply latch, sound->main. snd_reply_wr loads
//   data, sets main_reply_rdy; main_reply_rd clears it; same-cycle wr+rd leaves rdy=1.
//  Undefined: reply inputs ignored, main_reply_dout=0, main_reply_rdy=0; ports kept.
// STRUCTURE
//  jtcontra_sndq_pkg: IRQ_MODE_LEVEL/IRQ_MODE_STICKY constants, CHW derivation function.
//  Sub-module jtcontra_sndq_fifo (one channel: mem, pointers, count, hold, ovf),
//   instantiated CH times in a generate loop; top holds muxing, IRQ and reply logic.
// TESTING
//  1 Reset, CH=2 AW=2 -> snd_empty=2'b11, irq_n=1, snd_dout=0, ovf=0.
//  2 Write 0x12,0x34 to ch0, mode 0 -> irq_n=0 one cycle after first write;
//    snd_dout=0x12; pop -> 0x34; pop -> empty, irq_n=1, snd_dout holds 0x34.
//  3 Five writes 0xA0..0xA4 to ch1 -> main_full[1]=1, ovf[1]=1, pops give A0..A3;
//    irq_ack -> ovf=0.
//  4 Full ch0, pop+write 0x55 same cycle -> count stays 4, ovf[0]=0, 0x55 last out.
//  5 IRQ_MODE=1: write and irq_ack same cycle -> irq_n stays 0; lone ack -> irq_n=1.
//  6 REPLY_EN: snd_reply_wr 0x7E -> main_reply_rdy=1, dout=0x7E; main_reply_rd -> rdy=0.

Source files
------------

// File: rtl/jtcontra_sndq_pkg.sv
// Shared constants and helpers for the sound command queue.
// Optional reply latch enabled by defining JTCONTRA_SNDQ_REPLY_EN.
package jtcontra_sndq_pkg;

    localparam int IRQ_MODE_LEVEL  = 0;
    localparam int IRQ_MODE_STICKY = 1;

    function automatic int chw_f(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/jtcontra_sndq_fifo.sv
// One command channel: circular buffer with occupancy count, last-popped hold
// register and sticky overflow flag.
module jtcontra_sndq_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    input  logic          ovf_clr,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          push
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic [DW-1:0] hold_r;
    logic          ovf_r;
    logic          pop_s;
    logic          drop_s;

    assign empty  = (cnt_r == {(AW+1){1'b0}});
    assign full   = (cnt_r == (AW+1)'(DEPTH));
    // A pop on a full channel frees the slot the same cycle, so the push still lands
    assign pop_s  = rd & ~empty;
    assign push   = wr & (~full | pop_s);
    assign drop_s = wr & full & ~pop_s;
    assign head   = empty ? hold_r : mem_r[rd_ptr_r];
    assign ovf    = ovf_r;

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, hold register and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
            hold_r   <= {DW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                hold_r   <= mem_r[rd_ptr_r];
            end
            case ({push, pop_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtcontra_snd_cmdq.sv
// Multi-channel main->sound command queue with queue-derived IRQ.
// Define JTCONTRA_SNDQ_REPLY_EN to add the sound->main reply latch.
module jtcontra_snd_cmdq
    import jtcontra_sndq_pkg::*;
#(
    parameter  int CH       = 2,
    parameter  int DW       = 8,
    parameter  int AW       = 2,
    parameter  int IRQ_MODE = 0,
    localparam int CHW      = chw_f(CH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           main_wr,
    input  logic [CHW-1:0] main_ch,
    input  logic [DW-1:0]  main_din,
    output logic [CH-1:0]  main_full,
    input  logic           snd_rd,
    input  logic [CHW-1:0] snd_ch,
    output logic [DW-1:0]  snd_dout,
    output logic [CH-1:0]  snd_empty,
    output logic [CH-1:0]  ovf,
    input  logic           irq_ack,
    output logic           irq_n,
    input  logic           snd_reply_wr,
    input  logic [DW-1:0]  snd_reply_din,
    input  logic           main_reply_rd,
    output logic [DW-1:0]  main_reply_dout,
    output logic           main_reply_rdy
);

    logic [CH-1:0][DW-1:0] head_s;
    logic [CH-1:0]         push_s;
    logic                  irq_n_r;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        jtcontra_sndq_fifo #(.DW(DW), .AW(AW)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr      (main_wr && (main_ch == CHW'(c))),
            .din     (main_din),
            .rd      (snd_rd && (snd_ch == CHW'(c))),
            .ovf_clr (irq_ack),
            .head    (head_s[c]),
            .empty   (snd_empty[c]),
            .full    (main_full[c]),
            .ovf     (ovf[c]),
            .push    (push_s[c])
        );
    end

    // Channels beyond CH read back as zero
    assign snd_dout = (int'(snd_ch) < CH) ? head_s[snd_ch] : {DW{1'b0}};
    assign irq_n    = irq_n_r;

    if (IRQ_MODE == IRQ_MODE_STICKY) begin : g_irq_sticky
        // Sticky request: any accepted write sets it, ack clears it, set wins
        always_ff @(posedge clk) begin
            if (rst) begin
                irq_n_r <= 1'b1;
            end else if (|push_s) begin
                irq_n_r <= 1'b0;
            end else if (irq_ack) begin
                irq_n_r <= 1'b1;
            end else begin
                irq_n_r <= irq_n_r;
            end
        end
    end else begin : g_irq_level
        // Level request asserted while any channel holds data
        always_ff @(posedge clk) begin
            if (rst) begin
                irq_n_r <= 1'b1;
            end else begin
                irq_n_r <= &snd_empty;
            end
        end
    end

`ifdef JTCONTRA_SNDQ_REPLY_EN
    logic [DW-1:0] reply_dout_r;
    logic          reply_rdy_r;

    // Reply latch; a fresh write keeps the ready flag up over a same-cycle read
    always_ff @(posedge clk) begin
        if (rst) begin
            reply_dout_r <= {DW{1'b0}};
            reply_rdy_r  <= 1'b0;
        end else if (snd_reply_wr) begin
            reply_dout_r <= snd_reply_din;
            reply_rdy_r  <= 1'b1;
        end else if (main_reply_rd) begin
            reply_rdy_r  <= 1'b0;
        end else begin
            reply_rdy_r  <= reply_rdy_r;
        end
    end

    assign main_reply_dout = reply_dout_r;
    assign main_reply_rdy  = reply_rdy_r;
`else
    logic unused_reply_s;

    assign unused_reply_s  = ^{snd_reply_wr, snd_reply_din, main_reply_rd};
    assign main_reply_dout = {DW{1'b0}};
    assign main_reply_rdy  = 1'b0;
`endif

endmodule
